// File: rtl/addsub16_diff.sv
// addsub16_diff -- differencing stage for a 16-bit accumulated sample stream.
//
// Recovers the per-step increment between consecutive samples with a
// borrow/wrap flag. One-cycle registered latency.
//
// Ports:
//   CLK     in   rising-edge clock
//   RST     in   synchronous active-high reset
//   EN      in   sample strobe
//   LOAD    in   active-low re-prime (captures DATA, no difference)
//   ctl     in   0: DOUT = DATA - prev, 1: DOUT = prev - DATA
//   DATA    in   [15:0] accumulated sample
//   DOUT    out  [15:0] recovered step, modulo 2^16
//   BOUT    out  borrow, subtraction wrapped
//   VALID   out  one-cycle pulse on each new difference
//   PRIMED  out  reference register holds a valid sample
//   CNT     out  [7:0] differences since last prime, saturating at 255
//   STEADY  out  (only with ADDSUB16_DIFF_STEADY_EN) step repeated the
//                previous difference exactly
//
// Optional feature macro: ADDSUB16_DIFF_STEADY_EN

module addsub16_diff (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic        ctl,
  input  logic [15:0] DATA,
  output logic [15:0] DOUT,
  output logic        BOUT,
  output logic        VALID,
  output logic        PRIMED,
  output logic [7:0]  CNT
`ifdef ADDSUB16_DIFF_STEADY_EN
  ,
  output logic        STEADY
`endif
);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_PRIMED = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] prev;
  logic [16:0] diff;
  logic        prime;

  // 17-bit subtraction: bit 16 is the borrow out.
  always_comb begin
    diff = '0;
    if (ctl) diff = {1'b0, prev} - {1'b0, DATA};
    else     diff = {1'b0, DATA} - {1'b0, prev};
  end

  // LOAD is active-low; an EMPTY reference also forces a prime.
  assign prime  = !LOAD || (state == ST_EMPTY);
  assign PRIMED = (state == ST_PRIMED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_EMPTY;
      prev  <= '0;
      DOUT  <= '0;
      BOUT  <= 1'b0;
      VALID <= 1'b0;
      CNT   <= '0;
    end else begin
      VALID <= 1'b0;
      if (EN) begin
        prev <= DATA;
        if (prime) begin
          state <= ST_PRIMED;
          CNT   <= '0;
        end else begin
          {BOUT, DOUT} <= diff;
          VALID        <= 1'b1;
          if (CNT != 8'hFF) CNT <= CNT + 8'd1;
        end
      end
    end
  end

`ifdef ADDSUB16_DIFF_STEADY_EN
  logic [15:0] last_step;
  logic        last_ctl;
  logic        last_vld;

  // The previous difference's borrow is still held in BOUT, so only the
  // step and direction need a separate copy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_step <= '0;
      last_ctl  <= 1'b0;
      last_vld  <= 1'b0;
      STEADY    <= 1'b0;
    end else if (EN) begin
      if (prime) begin
        last_vld <= 1'b0;
        STEADY   <= 1'b0;
      end else begin
        last_step <= diff[15:0];
        last_ctl  <= ctl;
        last_vld  <= 1'b1;
        STEADY    <= last_vld && (CNT != 8'd0) && (diff[15:0] == last_step)
                     && (diff[16] == BOUT) && (ctl == last_ctl);
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub16_diff.sv
// tb_addsub16_diff -- directed self-checking bench for addsub16_diff.
// Checks STEADY as well when built with ADDSUB16_DIFF_STEADY_EN.

module tb_addsub16_diff;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        LOAD;
  logic        ctl;
  logic [15:0] DATA;
  logic [15:0] DOUT;
  logic        BOUT;
  logic        VALID;
  logic        PRIMED;
  logic [7:0]  CNT;
`ifdef ADDSUB16_DIFF_STEADY_EN
  logic        STEADY;
`endif

  int checks   = 0;
  int failures = 0;

  addsub16_diff dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .LOAD   (LOAD),
    .ctl    (ctl),
    .DATA   (DATA),
    .DOUT   (DOUT),
    .BOUT   (BOUT),
    .VALID  (VALID),
    .PRIMED (PRIMED),
    .CNT    (CNT)
`ifdef ADDSUB16_DIFF_STEADY_EN
    ,
    .STEADY (STEADY)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic en, input logic load, input logic c, input logic [15:0] d);
    EN   = en;
    LOAD = load;
    ctl  = c;
    DATA = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_diff(input string tag, input logic [15:0] d, input logic b,
                          input logic [7:0] n);
    chk({tag, "_valid"}, 32'(VALID), 32'd1);
    chk({tag, "_dout"},  32'(DOUT),  32'(d));
    chk({tag, "_bout"},  32'(BOUT),  32'(b));
    chk({tag, "_cnt"},   32'(CNT),   32'(n));
  endtask

  task automatic chk_steady(input string tag, input logic s);
`ifdef ADDSUB16_DIFF_STEADY_EN
    chk({tag, "_steady"}, 32'(STEADY), 32'(s));
`else
    if (s && !s) $display("%s", tag);
`endif
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b1; ctl = 1'b0; DATA = '0;

    // Reset with EN toggling.
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 16'h5678);
    chk("rst_dout",   32'(DOUT),   32'd0);
    chk("rst_bout",   32'(BOUT),   32'd0);
    chk("rst_valid",  32'(VALID),  32'd0);
    chk("rst_primed", 32'(PRIMED), 32'd0);
    chk("rst_cnt",    32'(CNT),    32'd0);
    chk_steady("rst", 1'b0);
    RST = 1'b0;

    // Up stream 0,16,32,48: first EN only primes.
    step(1'b1, 1'b1, 1'b0, 16'd0);
    chk("up_prime_valid",  32'(VALID),  32'd0);
    chk("up_prime_primed", 32'(PRIMED), 32'd1);
    chk("up_prime_cnt",    32'(CNT),    32'd0);
    step(1'b1, 1'b1, 1'b0, 16'd16);
    chk_diff("up1", 16'd16, 1'b0, 8'd1);
    chk_steady("up1", 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'd32);
    chk_diff("up2", 16'd16, 1'b0, 8'd2);
    chk_steady("up2", 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'd48);
    chk_diff("up3", 16'd16, 1'b0, 8'd3);
    chk_steady("up3", 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'd99);
    chk("up_idle_valid", 32'(VALID), 32'd0);
    chk("up_idle_dout",  32'(DOUT),  32'd16);
    chk("up_idle_cnt",   32'(CNT),   32'd3);

    // Wrap: prime 0xFFF8 via LOAD, then 0x0008 up, then 0x0000 down.
    step(1'b1, 1'b0, 1'b0, 16'hFFF8);
    chk("wrap_load_valid", 32'(VALID), 32'd0);
    chk("wrap_load_cnt",   32'(CNT),   32'd0);
    chk("wrap_load_dout",  32'(DOUT),  32'd16);
    step(1'b1, 1'b1, 1'b0, 16'h0008);
    chk_diff("wrap_up", 16'h0010, 1'b1, 8'd1);
    chk_steady("wrap_up", 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0000);
    chk_diff("wrap_dn", 16'h0008, 1'b0, 8'd2);
    chk_steady("wrap_dn", 1'b0);
    // Equal samples: valid zero step.
    step(1'b1, 1'b1, 1'b1, 16'h0000);
    chk_diff("zero", 16'h0000, 1'b0, 8'd3);

    // LOAD re-prime mid-stream.
    step(1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'd16);
    chk_diff("rl_pre", 16'd16, 1'b0, 8'd1);
    step(1'b1, 1'b0, 1'b0, 16'h1000);
    chk("rl_load_valid", 32'(VALID), 32'd0);
    chk("rl_load_cnt",   32'(CNT),   32'd0);
    chk("rl_load_dout",  32'(DOUT),  32'd16);
    step(1'b1, 1'b1, 1'b0, 16'h1004);
    chk_diff("rl_post", 16'd4, 1'b0, 8'd1);
    chk_steady("rl_post", 1'b0);
    // Down direction with borrow: 0x1004 - 0x1010.
    step(1'b1, 1'b1, 1'b1, 16'h1010);
    chk_diff("dn_borrow", 16'hFFF4, 1'b1, 8'd2);

    // EN low for 5 cycles: LOAD and DATA must be ignored.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'(i * 7 + 3));
      chk("hold_valid",  32'(VALID),  32'd0);
      chk("hold_dout",   32'(DOUT),   32'hFFF4);
      chk("hold_bout",   32'(BOUT),   32'd1);
      chk("hold_cnt",    32'(CNT),    32'd2);
      chk("hold_primed", 32'(PRIMED), 32'd1);
    end

    // Saturation: 300 unit steps after a fresh prime.
    step(1'b1, 1'b0, 1'b0, 16'd0);
    chk("sat_prime_cnt", 32'(CNT), 32'd0);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'(i));
      chk_diff("sat", 16'd1, 1'b0, (i > 255) ? 8'd255 : 8'(i));
      chk_steady("sat", i >= 2);
    end

    // Mid-stream reset together with LOAD=0: reset wins.
    RST = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h0777);
    chk("mrst_primed", 32'(PRIMED), 32'd0);
    chk("mrst_valid",  32'(VALID),  32'd0);
    chk("mrst_cnt",    32'(CNT),    32'd0);
    chk("mrst_dout",   32'(DOUT),   32'd0);
    chk_steady("mrst", 1'b0);
    RST = 1'b0;
    step(1'b1, 1'b1, 1'b0, 16'h0200);
    chk("mrst_prime_valid",  32'(VALID),  32'd0);
    chk("mrst_prime_primed", 32'(PRIMED), 32'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0250);
    chk_diff("mrst_diff", 16'h0050, 1'b0, 8'd1);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("mrst_pulse_end", 32'(VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
